ir_frame_decoder: RTL and testbench

Parametrised serial remote-control frame decoder. It samples one serial bit per `clk` and detects a start pattern. It then shifts in an address field, a key field and an inverted-key field, checks the frame, and presents the decoded key with a held `ready` strobe. Compared with the fixed 8-bit decoder, it adds:
- configurable field widths;
- optional address matching;
- a start-pulse timeout;
- an error strobe;
- repeat-key detection.

It sits between the IR receiver front end and the key-event consumer.

---
 rtl/ir_frame_decoder.sv | 157 +++++++++++++++
 tb/tb_ir_frame_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_decoder.sv
// Serial remote-control frame decoder: start detection, address/key/inverted-key
// capture, integrity and address check, held ready strobe and repeat detection.
module ir_frame_decoder #(
    parameter int              KEY_W         = 8,
    parameter int              ADDR_W        = 16,
    parameter bit              CHECK_ADDR    = 1'b1,
    parameter logic [ADDR_W-1:0] EXPECTED_ADDR = ADDR_W'(16'h00FF),
    parameter int              HOLD_CYCLES   = 3,
    parameter int              START_MAX     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial,
    output logic              ready,
    output logic [KEY_W-1:0]  remote_key,
    output logic [ADDR_W-1:0] remote_addr,
    output logic              key_repeat,
    output logic              frame_err
);

    localparam int MAX_AK  = (ADDR_W > KEY_W) ? ADDR_W : KEY_W;
    localparam int MAX_HS  = (HOLD_CYCLES > START_MAX) ? HOLD_CYCLES : START_MAX;
    localparam int CNT_MAX = (MAX_AK > MAX_HS) ? MAX_AK : MAX_HS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        KEY   = 3'd3,
        INV   = 3'd4,
        CHECK = 3'd5,
        VALID = 3'd6
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]  addr_sh_r;
    logic [KEY_W-1:0]   key_sh_r;
    logic [KEY_W-1:0]   inv_sh_r;
    logic [ADDR_W-1:0]  last_addr_r;
    logic [KEY_W-1:0]   last_key_r;
    logic               last_valid_r;
    logic               frame_ok_s;
    logic               same_as_last_s;

    // Integrity: key and inverted key must be exact complements; address optionally filtered.
    function automatic logic frame_ok(input logic [KEY_W-1:0]  key,
                                      input logic [KEY_W-1:0]  inv,
                                      input logic [ADDR_W-1:0] addr);
        return (&(key ^ inv)) && (!CHECK_ADDR || (addr == EXPECTED_ADDR));
    endfunction

    assign frame_ok_s     = frame_ok(key_sh_r, inv_sh_r, addr_sh_r);
    assign same_as_last_s = last_valid_r && (key_sh_r == last_key_r) && (addr_sh_r == last_addr_r);

    // Frame state machine with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            addr_sh_r    <= '0;
            key_sh_r     <= '0;
            inv_sh_r     <= '0;
            last_addr_r  <= '0;
            last_key_r   <= '0;
            last_valid_r <= 1'b0;
            ready        <= 1'b0;
            remote_key   <= '1;
            remote_addr  <= '0;
            key_repeat   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (!serial) begin
                        state_r <= START;
                    end
                end
                START: begin
                    // A start pulse that stays low too long is dropped without an error.
                    if (serial) begin
                        cnt_r   <= '0;
                        state_r <= ADDR;
                    end else if (cnt_r == CNT_W'(START_MAX - 1)) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ADDR: begin
                    addr_sh_r <= ADDR_W'({addr_sh_r, serial});
                    if (cnt_r == CNT_W'(ADDR_W - 1)) begin
                        cnt_r   <= '0;
                        state_r <= KEY;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                KEY: begin
                    key_sh_r <= KEY_W'({key_sh_r, serial});
                    if (cnt_r == CNT_W'(KEY_W - 1)) begin
                        cnt_r   <= '0;
                        state_r <= INV;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                INV: begin
                    inv_sh_r <= KEY_W'({inv_sh_r, serial});
                    if (cnt_r == CNT_W'(KEY_W - 1)) begin
                        cnt_r   <= '0;
                        state_r <= CHECK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                CHECK: begin
                    cnt_r <= '0;
                    if (frame_ok_s) begin
                        ready        <= 1'b1;
                        remote_key   <= key_sh_r;
                        remote_addr  <= addr_sh_r;
                        key_repeat   <= same_as_last_s;
                        last_key_r   <= key_sh_r;
                        last_addr_r  <= addr_sh_r;
                        last_valid_r <= 1'b1;
                        state_r      <= VALID;
                    end else begin
                        frame_err <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                VALID: begin
                    // serial is deliberately ignored while the key is presented.
                    if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_r      <= '0;
                        ready      <= 1'b0;
                        remote_key <= '1;
                        key_repeat <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Bench for ir_frame_decoder: three configurations driven from a frame table,
// outputs checked against a per-instance scoreboard, plus timeout and reset sequences.
module tb_ir_frame_decoder;

    typedef struct {
        bit          err;
        logic [15:0] key;
        logic [15:0] addr;
        bit          rep;
        int          cyc;
    } exp_t;

    typedef struct {
        int          inst;
        logic [15:0] addr;
        logic [15:0] key;
        logic [15:0] inv;
        bit          err;
        bit          rep;
    } vec_t;

    localparam int KW [3] = '{8, 8, 12};
    localparam int AW [3] = '{16, 16, 8};
    localparam int HW [3] = '{3, 3, 5};
    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  ser = 3'b111;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    bit          prev_rdy [3];
    int          hold_cnt [3];
    vec_t        vecs [NV];

    logic        rdy0, rdy1, rdy2, err0, err1, err2, rep0, rep1, rep2;
    logic [7:0]  key0, key1, addr2;
    logic [11:0] key2;
    logic [15:0] addr0, addr1;

    ir_frame_decoder u_dut0 (
        .clk(clk), .reset(rst_n), .serial(ser[0]), .ready(rdy0), .remote_key(key0),
        .remote_addr(addr0), .key_repeat(rep0), .frame_err(err0)
    );

    ir_frame_decoder #(.CHECK_ADDR(1'b0)) u_dut1 (
        .clk(clk), .reset(rst_n), .serial(ser[1]), .ready(rdy1), .remote_key(key1),
        .remote_addr(addr1), .key_repeat(rep1), .frame_err(err1)
    );

    ir_frame_decoder #(.KEY_W(12), .ADDR_W(8), .EXPECTED_ADDR(8'hFF), .HOLD_CYCLES(5)) u_dut2 (
        .clk(clk), .reset(rst_n), .serial(ser[2]), .ready(rdy2), .remote_key(key2),
        .remote_addr(addr2), .key_repeat(rep2), .frame_err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int i, input bit rdy, input bit err, input logic [15:0] key,
                       input logic [15:0] addr, input bit rep);
        exp_t e;
        int   n;
        n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (rdy || err) chk($sformatf("dut%0d_ready_err_exclusive", i), 32'(rdy & err), 32'd0);
        if ((rdy && !prev_rdy[i]) || err) begin
            if (n == 0) begin
                n_chk++;
                $display("FAIL dut%0d_unexpected_output: ready=%0b frame_err=%0b at cycle %0d with no frame pending",
                         i, rdy, err, cyc);
            end else begin
                case (i)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("dut%0d_err", i), 32'(err), 32'(e.err));
                chk($sformatf("dut%0d_latency", i), 32'(cyc), 32'(e.cyc));
                if (!e.err) begin
                    chk($sformatf("dut%0d_key", i), 32'(key), 32'(e.key));
                    chk($sformatf("dut%0d_addr", i), 32'(addr), 32'(e.addr));
                    chk($sformatf("dut%0d_repeat", i), 32'(rep), 32'(e.rep));
                end
            end
        end
        if (rdy) hold_cnt[i]++;
        if (!rdy && prev_rdy[i]) begin
            chk($sformatf("dut%0d_hold", i), 32'(hold_cnt[i]), 32'(HW[i]));
            chk($sformatf("dut%0d_key_idle", i), 32'(key), (32'd1 << KW[i]) - 32'd1);
            chk($sformatf("dut%0d_repeat_idle", i), 32'(rep), 32'd0);
            hold_cnt[i] = 0;
        end
        prev_rdy[i] = rdy;
    endtask

    always @(negedge clk) begin
        mon(0, rdy0, err0, 16'(key0), addr0, rep0);
        mon(1, rdy1, err1, 16'(key1), addr1, rep1);
        mon(2, rdy2, err2, 16'(key2), 16'(addr2), rep2);
    end

    task automatic drive_bit(input int i, input bit b);
        ser[i] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_field(input int i, input logic [15:0] v, input int w);
        for (int b = w - 1; b >= 0; b--) drive_bit(i, v[b]);
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        drive_bit(v.inst, 1'b0);
        drive_bit(v.inst, 1'b1);
        e.err  = v.err;
        e.key  = v.key;
        e.addr = v.addr;
        e.rep  = v.rep;
        e.cyc  = cyc + AW[v.inst] + 2 * KW[v.inst] + 1;
        sb_push(v.inst, e);
        send_field(v.inst, v.addr, AW[v.inst]);
        send_field(v.inst, v.key, KW[v.inst]);
        send_field(v.inst, v.inv, KW[v.inst]);
        // Next start lands exactly in the first idle cycle after the hold.
        for (int k = 0; k < HW[v.inst] + 1; k++) drive_bit(v.inst, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 16'h00FF, 16'h0045, 16'h00BA, 1'b0, 1'b0};
        vecs[1]  = '{0, 16'h00FF, 16'h0045, 16'h00BA, 1'b0, 1'b1};
        vecs[2]  = '{0, 16'h00FF, 16'h0045, 16'h00BB, 1'b1, 1'b0};
        vecs[3]  = '{0, 16'h00FF, 16'h0045, 16'h00BA, 1'b0, 1'b1};
        vecs[4]  = '{0, 16'h00FF, 16'h0046, 16'h00B9, 1'b0, 1'b0};
        vecs[5]  = '{0, 16'h1234, 16'h0045, 16'h00BA, 1'b1, 1'b0};
        vecs[6]  = '{0, 16'h00FF, 16'h0046, 16'h00B9, 1'b0, 1'b1};
        vecs[7]  = '{0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b0};
        vecs[8]  = '{1, 16'h1234, 16'h0045, 16'h00BA, 1'b0, 1'b0};
        vecs[9]  = '{1, 16'h1234, 16'h0045, 16'h00BA, 1'b0, 1'b1};
        vecs[10] = '{1, 16'hABCD, 16'h0045, 16'h00BA, 1'b0, 1'b0};
        vecs[11] = '{1, 16'hABCD, 16'h0045, 16'h00B0, 1'b1, 1'b0};
        vecs[12] = '{2, 16'h00FF, 16'h0345, 16'h0CBA, 1'b0, 1'b0};
        vecs[13] = '{2, 16'h00FF, 16'h0345, 16'h0CBA, 1'b0, 1'b1};
        vecs[14] = '{2, 16'h00FF, 16'h0345, 16'h0CBB, 1'b1, 1'b0};
        vecs[15] = '{2, 16'h007E, 16'h0345, 16'h0CBA, 1'b1, 1'b0};
        vecs[16] = '{2, 16'h00FF, 16'h0FFF, 16'h0000, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_key", 32'(key0), 32'h0FF);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_repeat", 32'(rep0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_key_w12", 32'(key2), 32'hFFF);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) send_frame(vecs[k]);
        repeat (10) @(posedge clk);
        #1;

        // Two back-to-back start timeouts, then a clean frame must still align.
        for (int k = 0; k < 34; k++) drive_bit(0, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(0, 1'b1);
        send_frame('{0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b1});
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of the key field.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        send_field(0, 16'h00FF, 16);
        send_field(0, 16'h0004, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy0), 32'd0);
        chk("midrst_key", 32'(key0), 32'h0FF);
        chk("midrst_addr", 32'(addr0), 32'd0);
        chk("midrst_repeat", 32'(rep0), 32'd0);
        chk("midrst_err", 32'(err0), 32'd0);
        ser[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) drive_bit(0, 1'b1);
        send_frame('{0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b0});

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
